// File: rtl/flash_pkg.sv
// Shared types and configuration helpers for the Wishbone-to-NOR-flash read controller.
package flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  // Word-address width: window flag + base register + window offset.
  function automatic int calc_waw(input int base_w, input int win_off_w);
    return 1 + base_w + win_off_w;
  endfunction

  function automatic int calc_flash_aw(input int base_w, input int win_off_w, input int byte_mode);
    return calc_waw(base_w, win_off_w) + byte_mode;
  endfunction

  // A linear 16-bit word address must fit into the word-address space.
  function automatic bit cfg_ok(input int base_w, input int win_off_w);
    return calc_waw(base_w, win_off_w) >= 16;
  endfunction

endpackage

// File: rtl/wb_flash_ctrl.sv
// Wishbone classic slave giving 16-bit read access to asynchronous NOR flash,
// with programmable wait states, a windowed address mode and optional 8-bit flash bus.
module wb_flash_ctrl
  import flash_pkg::*;
#(
  parameter int BASE_W      = 12,
  parameter int WIN_OFF_W   = 9,
  parameter int WAIT_CYCLES = 4,
  parameter int BYTE_MODE   = 0,
  localparam int FLASH_AW   = calc_flash_aw(BASE_W, WIN_OFF_W, BYTE_MODE)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  input  logic [16:1]         wb_adr_i,
  input  logic                wb_we_i,
  input  logic                wb_tga_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic [1:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic [FLASH_AW-1:0] flash_addr_,
  input  logic [15:0]         flash_data_,
  output logic                flash_we_n_,
  output logic                flash_oe_n_,
  output logic                flash_ce_n_,
  output logic                flash_rst_n_,
  output logic                flash_byte_n_
);

  localparam int WAW = calc_waw(BASE_W, WIN_OFF_W);

  if (!cfg_ok(BASE_W, WIN_OFF_W)) begin : g_bad_cfg
    $error("wb_flash_ctrl: 1+BASE_W+WIN_OFF_W must be at least 16");
  end

  state_t            state;
  logic [BASE_W-1:0] base;
  logic [3:0]        count;
  logic [15:0]       rd_data;
  logic              cur_lane;
  logic              lane_pending;

  logic              op;
  logic [1:0]        sel_eff;
  logic [WAW-1:0]    word_addr;
  logic [15:0]       sampled;
  logic              unused_dat;

  assign op            = wb_stb_i & wb_cyc_i;
  assign sel_eff       = (wb_sel_i == 2'b00) ? 2'b11 : wb_sel_i;
  assign flash_we_n_   = 1'b1;
  assign flash_rst_n_  = 1'b1;
  assign flash_byte_n_ = (BYTE_MODE == 0);
  assign unused_dat    = ^wb_dat_i;

  always_comb begin
    if (wb_tga_i) word_addr = {1'b1, base, wb_adr_i[WIN_OFF_W:1]};
    else          word_addr = WAW'(wb_adr_i);
  end

  // Merge the current flash sample into the partially assembled word.
  always_comb begin
    sampled = rd_data;
    if (BYTE_MODE == 0) sampled = flash_data_;
    else if (cur_lane)  sampled[15:8] = flash_data_[7:0];
    else                sampled[7:0]  = flash_data_[7:0];
  end

  // NOTE: every register below uses <= so all updates see pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      base         <= '0;
      flash_ce_n_  <= 1'b1;
      flash_oe_n_  <= 1'b1;
      flash_addr_  <= '0;
      count        <= '0;
      rd_data      <= '0;
      cur_lane     <= 1'b0;
      lane_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          if (op) begin
            if (wb_we_i) begin
              if (wb_tga_i) begin
                for (int i = 0; i < BASE_W; i++) begin
                  if (i < 8 ? wb_sel_i[0] : wb_sel_i[1]) base[i] <= wb_dat_i[i];
                end
              end
              state    <= ACK;
              wb_ack_o <= 1'b1;
            end else begin
              state       <= ACCESS;
              flash_ce_n_ <= 1'b0;
              flash_oe_n_ <= 1'b0;
              count       <= 4'(WAIT_CYCLES - 1);
              rd_data     <= '0;
              if (BYTE_MODE != 0) begin
                flash_addr_  <= FLASH_AW'({word_addr, ~sel_eff[0]});
                cur_lane     <= ~sel_eff[0];
                lane_pending <= &sel_eff;
              end else begin
                flash_addr_ <= FLASH_AW'(word_addr);
              end
            end
          end
        end

        ACCESS: begin
          if (!op) begin
            state       <= IDLE;
            flash_ce_n_ <= 1'b1;
            flash_oe_n_ <= 1'b1;
          end else if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            rd_data <= sampled;
            if (lane_pending) begin
              // Second byte lane follows immediately with the strobes kept low.
              lane_pending   <= 1'b0;
              cur_lane       <= 1'b1;
              flash_addr_[0] <= 1'b1;
              count          <= 4'(WAIT_CYCLES - 1);
            end else begin
              state       <= ACK;
              wb_ack_o    <= 1'b1;
              wb_dat_o    <= sampled;
              flash_ce_n_ <= 1'b1;
              flash_oe_n_ <= 1'b1;
            end
          end
        end

        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_flash_ctrl.sv
// Directed bench for wb_flash_ctrl: default, 8-bit-bus and single-wait-state instances.
module tb_wb_flash_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dat_in;
  logic [16:1] adr;
  logic        we, tga, cyc;
  logic [2:0]  stb;
  logic [1:0]  sel;

  logic        ack0, ack1, ack2;
  logic [15:0] dat0, dat1, dat2;
  logic [21:0] fa0, fa2;
  logic [22:0] fa1;
  logic [15:0] fd0, fd1, fd2;
  logic        we_n0, we_n1, we_n2, oe_n0, oe_n1, oe_n2, ce_n0, ce_n1, ce_n2;
  logic        rn0, rn1, rn2, bn0, bn1, bn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Word flash: one marked location, everything else a simple address pattern.
  function automatic logic [15:0] word_model(input logic [21:0] a);
    return (a == 22'h001234) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  // Byte flash: upper data lines driven high so the DUT must ignore them.
  function automatic logic [15:0] byte_model(input logic [22:0] a);
    logic [7:0] b;
    case (a)
      23'h000020: b = 8'h34;
      23'h000021: b = 8'h12;
      default:    b = a[7:0];
    endcase
    return {8'hFF, b};
  endfunction

  assign fd0 = word_model(fa0);
  assign fd1 = byte_model(fa1);
  assign fd2 = word_model(fa2);

  wb_flash_ctrl u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(dat_in), .wb_dat_o(dat0), .wb_adr_i(adr),
    .wb_we_i(we), .wb_tga_i(tga), .wb_stb_i(stb[0]), .wb_cyc_i(cyc), .wb_sel_i(sel),
    .wb_ack_o(ack0), .flash_addr_(fa0), .flash_data_(fd0), .flash_we_n_(we_n0),
    .flash_oe_n_(oe_n0), .flash_ce_n_(ce_n0), .flash_rst_n_(rn0), .flash_byte_n_(bn0)
  );

  wb_flash_ctrl #(.BYTE_MODE(1)) u_byte (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(dat_in), .wb_dat_o(dat1), .wb_adr_i(adr),
    .wb_we_i(we), .wb_tga_i(tga), .wb_stb_i(stb[1]), .wb_cyc_i(cyc), .wb_sel_i(sel),
    .wb_ack_o(ack1), .flash_addr_(fa1), .flash_data_(fd1), .flash_we_n_(we_n1),
    .flash_oe_n_(oe_n1), .flash_ce_n_(ce_n1), .flash_rst_n_(rn1), .flash_byte_n_(bn1)
  );

  wb_flash_ctrl #(.WAIT_CYCLES(1)) u_fast (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(dat_in), .wb_dat_o(dat2), .wb_adr_i(adr),
    .wb_we_i(we), .wb_tga_i(tga), .wb_stb_i(stb[2]), .wb_cyc_i(cyc), .wb_sel_i(sel),
    .wb_ack_o(ack2), .flash_addr_(fa2), .flash_data_(fd2), .flash_we_n_(we_n2),
    .flash_oe_n_(oe_n2), .flash_ce_n_(ce_n2), .flash_rst_n_(rn2), .flash_byte_n_(bn2)
  );

  function automatic logic get_ack(input int idx);
    return (idx == 0) ? ack0 : (idx == 1) ? ack1 : ack2;
  endfunction
  function automatic logic get_ce(input int idx);
    return (idx == 0) ? ce_n0 : (idx == 1) ? ce_n1 : ce_n2;
  endfunction
  function automatic logic get_oe(input int idx);
    return (idx == 0) ? oe_n0 : (idx == 1) ? oe_n1 : oe_n2;
  endfunction
  function automatic logic [15:0] get_dat(input int idx);
    return (idx == 0) ? dat0 : (idx == 1) ? dat1 : dat2;
  endfunction
  function automatic logic [22:0] get_addr(input int idx);
    return (idx == 0) ? {1'b0, fa0} : (idx == 1) ? fa1 : {1'b0, fa2};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; lat counts edges including the accepting one, -1 on timeout.
  task automatic run_txn(input int idx, input logic w, input logic t, input logic [1:0] s,
                         input logic [15:0] a, input logic [15:0] d,
                         output int lat, output int low,
                         output logic [22:0] first_a, output logic [22:0] last_a,
                         output logic [15:0] rd);
    lat = -1; low = 0; first_a = '0; last_a = '0;
    we = w; tga = t; sel = s; adr = a; dat_in = d; cyc = 1'b1; stb[idx] = 1'b1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (!get_ce(idx) && !get_oe(idx)) begin
        if (low == 0) first_a = get_addr(idx);
        last_a = get_addr(idx);
        low++;
      end
      if (get_ack(idx)) lat = n;
    end
    rd = get_dat(idx);
    stb = '0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  int          lat, low, acks, gap;
  logic [22:0] fa, la;
  logic [15:0] rd;
  logic        seen_ack, done;

  initial begin
    rst = 1'b1; dat_in = '0; adr = '0; we = 1'b0; tga = 1'b0; cyc = 1'b0; stb = '0; sel = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_ack", ack0, 1'b0);
    check("rst_dat", dat0, 16'h0000);
    check("rst_ce_oe", {ce_n0, oe_n0}, 2'b11);
    check("rst_addr", fa0, 22'h0);
    check("const_pins", {we_n0, rn0, bn0, bn1}, 4'b1110);

    // Linear word read
    run_txn(0, 1'b0, 1'b0, 2'b11, 16'h1234, 16'h0, lat, low, fa, la, rd);
    check("lin_addr", fa, 23'h001234);
    check("lin_low", low, 4);
    check("lin_lat", lat, 5);
    check("lin_dat", rd, 16'hBEEF);

    // Base write then window read
    run_txn(0, 1'b1, 1'b1, 2'b11, 16'h0000, 16'h0ABC, lat, low, fa, la, rd);
    check("base_wr_lat", lat, 1);
    check("base_wr_low", low, 0);
    run_txn(0, 1'b0, 1'b1, 2'b11, 16'h0005, 16'h0, lat, low, fa, la, rd);
    check("win_addr", fa, 23'h357805);
    check("win_lat", lat, 5);
    check("win_dat", rd, 16'h225F);

    // Partial base write, then an ignored linear write
    run_txn(0, 1'b1, 1'b1, 2'b01, 16'h0000, 16'h0F12, lat, low, fa, la, rd);
    check("base_lo_lat", lat, 1);
    run_txn(0, 1'b1, 1'b0, 2'b11, 16'h0000, 16'hFFFF, lat, low, fa, la, rd);
    check("lin_wr_lat", lat, 1);
    check("lin_wr_low", low, 0);
    check("lin_wr_dat_kept", rd, 16'h225F);
    run_txn(0, 1'b0, 1'b1, 2'b11, 16'h0000, 16'h0, lat, low, fa, la, rd);
    check("win2_addr", fa, 23'h342400);
    check("win2_dat", rd, 16'h7E5A);

    // 8-bit flash bus
    run_txn(1, 1'b0, 1'b0, 2'b11, 16'h0010, 16'h0, lat, low, fa, la, rd);
    check("byte_first", fa, 23'h000020);
    check("byte_last", la, 23'h000021);
    check("byte_low", low, 8);
    check("byte_lat", lat, 9);
    check("byte_dat", rd, 16'h1234);
    run_txn(1, 1'b0, 1'b0, 2'b10, 16'h0010, 16'h0, lat, low, fa, la, rd);
    check("byte_hi_first", fa, 23'h000021);
    check("byte_hi_last", la, 23'h000021);
    check("byte_hi_lat", lat, 5);
    check("byte_hi_dat", rd, 16'h1200);

    // Abort by dropping cyc mid-access
    we = 1'b0; tga = 1'b0; sel = 2'b11; adr = 16'h0100; cyc = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_ce_low", {ce_n0, oe_n0}, 2'b00);
    cyc = 1'b0;
    @(posedge clk); #1;
    check("abort_ce_high", {ce_n0, oe_n0}, 2'b11);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (ack0) acks++;
      @(posedge clk); #1;
    end
    stb = '0;
    check("abort_no_ack", acks, 0);
    check("abort_dat", dat0, 16'h7E5A);
    run_txn(0, 1'b0, 1'b0, 2'b11, 16'h0042, 16'h0, lat, low, fa, la, rd);
    check("post_abort_lat", lat, 5);
    check("post_abort_dat", rd, 16'h5A18);

    // Reset in the middle of a window read
    we = 1'b0; tga = 1'b1; adr = 16'h0005; cyc = 1'b1; stb[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; stb = '0; cyc = 1'b0;
    check("rst_mid_ce", {ce_n0, oe_n0}, 2'b11);
    check("rst_mid_ack", ack0, 1'b0);
    check("rst_mid_dat", dat0, 16'h0000);
    @(posedge clk); #1;
    run_txn(0, 1'b0, 1'b1, 2'b11, 16'h0000, 16'h0, lat, low, fa, la, rd);
    check("rst_base_addr", fa, 23'h200000);
    check("rst_base_dat", rd, 16'h5A5A);

    // Single wait state
    run_txn(2, 1'b0, 1'b0, 2'b11, 16'h0007, 16'h0, lat, low, fa, la, rd);
    check("fast_low", low, 1);
    check("fast_lat", lat, 2);
    check("fast_dat", rd, 16'h5A5D);

    // Back-to-back reads with the strobe held
    we = 1'b0; tga = 1'b0; adr = 16'h0007; cyc = 1'b1; stb[2] = 1'b1;
    seen_ack = 1'b0; done = 1'b0; gap = -1;
    for (int n = 0; n < 30 && !done; n++) begin
      @(posedge clk); #1;
      if (seen_ack) begin
        if (!ce_n2) done = 1'b1;
        else if (!ack2) gap++;
      end else if (ack2) begin
        seen_ack = 1'b1;
        gap = 0;
      end
    end
    stb = '0; cyc = 1'b0;
    check("b2b_gap", gap, 1);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_flash_ctrl.md
Name: wb_flash_ctrl

Overview:
Wishbone classic slave giving 16-bit read access to asynchronous parallel NOR flash, with programmable access wait states and optional 8-bit flash bus mode. 16-bit flash mode needs one flash cycle per access; 8-bit mode needs two.
Two address modes: linear (wb_tga_i=0) and windowed (wb_tga_i=1, using a writable base register). The block sits between the CPU/ROM-BIOS Wishbone bus and the board flash pads. It is read-only toward the flash.

Parameters:
BASE_W, 12, window base register width (1..16).
WIN_OFF_W, 9, word-offset bits taken from wb_adr_i in windowed mode (1..16).
WAIT_CYCLES, 4, clocks flash_oe_n_ is held low per flash read (1..15).
BYTE_MODE, 0, 0 = 16-bit flash bus; 1 = 8-bit flash bus, two byte reads per word.
Derived: WAW = 1+BASE_W+WIN_OFF_W must be >= 16; FLASH_AW = WAW+BYTE_MODE.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active high
wb_dat_i  in  16  write data (base register)
wb_dat_o  out  16  registered read data
wb_adr_i  in  16 [16:1]  word address
wb_we_i  in  1  write enable
wb_tga_i  in  1  0 = linear, 1 = window/base
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_sel_i  in  2  byte selects
wb_ack_o  out  1  registered acknowledge
flash_addr_  out  FLASH_AW  flash address, registered
flash_data_  in  16  flash data; only [7:0] used when BYTE_MODE=1
flash_we_n_  out  1  constant 1
flash_oe_n_  out  1  output enable, active low, registered
flash_ce_n_  out  1  chip enable, active low, registered
flash_rst_n_  out  1  constant 1
flash_byte_n_  out  1  constant !BYTE_MODE

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active high.
- Reset values: state IDLE; wb_ack_o=0; wb_dat_o=0; base=0; flash_ce_n_=flash_oe_n_=1; flash_addr_=0. Reset mid-access aborts it at the next edge with no ack.
- op = wb_stb_i & wb_cyc_i. Requests are accepted only in IDLE.
- FSM states: IDLE, ACCESS, ACK.
- Writes:
  - Write with tga=1: base[7:0] is updated if sel[0]; base[BASE_W-1:8] is updated if sel[1] (bits limited to BASE_W). Transition IDLE->ACK; no flash strobes.
  - Write with tga=0: ignored (no state change). Transition IDLE->ACK.
- Read word address:
  - tga=0: zero-extended wb_adr_i[16:1], truncated to WAW bits.
  - tga=1: {1'b1, base, wb_adr_i[WIN_OFF_W:1]}.
  - BYTE_MODE=0: flash_addr_ = word address.
  - BYTE_MODE=1: flash_addr_ = {word address, lane}, lane 0 = low byte.
- Read sequence: IDLE->ACCESS loads flash_addr_, drives ce/oe low, and sets counter = WAIT_CYCLES-1. The counter decrements each edge. At the edge where counter==0, flash_data_ is sampled into the data register.
- BYTE_MODE=1 lanes: the lanes to read are the bits set in sel (sel=00 is treated as 11). The low lane is read first. Lane 0 data goes to dat[7:0], lane 1 data to dat[15:8]. An unselected lane reads as 8'h00. After the first lane completes, the address LSB switches and the counter reloads with no idle gap.
- After the final phase: ACCESS->ACK; ce/oe return high on the same edge.
- ACK state: wb_ack_o=1 for exactly one cycle, then ACK->IDLE. At least one IDLE cycle separates back-to-back accesses.
- Latency (edges from the accepting edge until wb_ack_o is high):
  - write: 1;
  - word-mode read: WAIT_CYCLES+1;
  - byte-mode read: n*WAIT_CYCLES+1, n = number of lanes.
- Abort: op low during ACCESS -> IDLE at the next edge; ce/oe high; no ack; wb_dat_o unchanged.
- wb_dat_o holds its last value between reads; it is not modified by writes.

Decomposition:
- Package flash_pkg:
  - state enum (IDLE, ACCESS, ACK);
  - function computing WAW/FLASH_AW;
  - compile-time check that 1+BASE_W+WIN_OFF_W >= 16.
- No sub-module: the wait counter and address mux are small enough to stay inline.

Test Plan:
1. Defaults; linear read of wb_adr_i=16'h1234; flash model returns 16'hBEEF -> flash_addr_=22'h001234; ce/oe low exactly 4 cycles; single-cycle ack 5 edges after acceptance; wb_dat_o=16'hBEEF.
2. Base write of wb_dat_i=16'h0ABC with sel=11, tga=1 -> ack after 1 edge with no ce. Then window read with offset 9'h005 -> flash_addr_=22'h357805.
3. Starting from base=12'hABC, write 16'h0F12 with sel=01 -> base=12'hA12. Then a tga=0 write -> ack after 1 edge, base unchanged, no flash strobes.
4. BYTE_MODE=1, read word 16'h0010 with sel=11; model returns 8'h34 @0x20 and 8'h12 @0x21 -> addresses 0x20 then 0x21; ack after 9 edges; dat_o=16'h1234. With sel=10: single phase @0x21; ack after 5 edges; dat_o=16'h1200.
5. Drop wb_cyc_i after 2 ACCESS cycles -> ce/oe high next edge, no ack, dat_o unchanged; the following read completes normally. Assert wb_rst_i mid-access -> same result, plus base=0 and dat_o=0.
6. WAIT_CYCLES=1 read -> ce/oe low 1 cycle, ack after 2 edges. Back-to-back reads with stb held high -> exactly one IDLE cycle between ack and the next ce assertion.
